// File: rtl/control_unit_if.sv
// Control bus between the microsequencer and the datapath: instruction fields
// and flags in, control word and trace signals out.
interface control_unit_if;
    logic [3:0]  opcode;
    logic [3:0]  operand;
    logic        flag_carry;
    logic        flag_zero;
    logic [15:0] control_word;
    logic [2:0]  step;
    logic        halt;

    modport master (
        input  opcode,
        input  operand,
        input  flag_carry,
        input  flag_zero,
        output control_word,
        output step,
        output halt
    );

    modport slave (
        output opcode,
        output operand,
        output flag_carry,
        output flag_zero,
        input  control_word,
        input  step,
        input  halt
    );
endinterface

// File: rtl/control_unit.sv
// Microsequencer: steps T-states through fetch/execute and decodes a control word.
// Optional SHORT_CYCLE_EN: wrap to T0 right after an opcode's last non-empty step.
module control_unit #(
    parameter int MAX_STEPS = 5
) (
    input  logic          clk,
    input  logic          reset,
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } mode_t;

    localparam logic [2:0] LAST_STEP = 3'(MAX_STEPS - 1);

    localparam logic [15:0] PC_ENABLE  = 16'h0001;
    localparam logic [15:0] LOAD_PC    = 16'h0002;
    localparam logic [15:0] OE_PC      = 16'h0004;
    localparam logic [15:0] LOAD_MAR   = 16'h0008;
    localparam logic [15:0] OE_RAM     = 16'h0010;
    localparam logic [15:0] LOAD_RAM   = 16'h0020;
    localparam logic [15:0] LOAD_IR    = 16'h0040;
    localparam logic [15:0] OE_IR      = 16'h0080;
    localparam logic [15:0] LOAD_A     = 16'h0100;
    localparam logic [15:0] OE_A       = 16'h0200;
    localparam logic [15:0] LOAD_B     = 16'h0400;
    localparam logic [15:0] ALU_SUB    = 16'h0800;
    localparam logic [15:0] OE_ALU     = 16'h1000;
    localparam logic [15:0] LOAD_FLAGS = 16'h2000;
    localparam logic [15:0] LOAD_O     = 16'h4000;
    localparam logic [15:0] HALT_BIT   = 16'h8000;

    opcode_t     op;
    mode_t       mode, mode_next;
    logic [2:0]  step_r, step_next;
    logic [15:0] cw;

    // The operand reaches the bus through the IR, not through this block.
    logic unused_operand;
    assign unused_operand = ^bus.operand;

    assign op = opcode_t'(bus.opcode);

    // Final step of the current instruction before wrapping to T0.
    function automatic logic [2:0] last_step(input opcode_t o);
`ifdef SHORT_CYCLE_EN
        case (o)
            OP_ADD, OP_SUB: last_step = 3'd4;
            OP_LDA, OP_STA: last_step = 3'd3;
            default:        last_step = 3'd2;
        endcase
`else
        last_step = (o == OP_HLT) ? 3'd2 : LAST_STEP;
`endif
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode   <= RUN;
            step_r <= 3'd0;
        end else begin
            mode   <= mode_next;
            step_r <= step_next;
        end
    end

    always_comb begin
        mode_next = mode;
        step_next = step_r;
        if (mode == RUN) begin
            // HLT freezes the counter on T2 instead of advancing past it.
            if (step_r == 3'd2 && op == OP_HLT) begin
                mode_next = HALTED;
            end else if (step_r >= 3'd2 && step_r >= last_step(op)) begin
                step_next = 3'd0;
            end else begin
                step_next = step_r + 3'd1;
            end
        end
    end

    always_comb begin
        cw = 16'h0000;
        if (reset) begin
            cw = 16'h0000;
        end else if (mode == HALTED) begin
            cw = HALT_BIT;
        end else begin
            case (step_r)
                3'd0: cw = OE_PC | LOAD_MAR;
                3'd1: cw = OE_RAM | LOAD_IR | PC_ENABLE;
                3'd2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: cw = OE_IR | LOAD_MAR;
                        OP_LDI: cw = OE_IR | LOAD_A;
                        OP_JMP: cw = OE_IR | LOAD_PC;
                        OP_JC:  cw = bus.flag_carry ? (OE_IR | LOAD_PC) : 16'h0000;
                        OP_JZ:  cw = bus.flag_zero  ? (OE_IR | LOAD_PC) : 16'h0000;
                        OP_OUT: cw = OE_A | LOAD_O;
                        OP_HLT: cw = HALT_BIT;
                        default: cw = 16'h0000;
                    endcase
                end
                3'd3: begin
                    case (op)
                        OP_LDA:         cw = OE_RAM | LOAD_A;
                        OP_ADD, OP_SUB: cw = OE_RAM | LOAD_B;
                        OP_STA:         cw = OE_A | LOAD_RAM;
                        default:        cw = 16'h0000;
                    endcase
                end
                3'd4: begin
                    case (op)
                        OP_ADD:  cw = OE_ALU | LOAD_A | LOAD_FLAGS;
                        OP_SUB:  cw = OE_ALU | LOAD_A | LOAD_FLAGS | ALU_SUB;
                        default: cw = 16'h0000;
                    endcase
                end
                default: cw = 16'h0000;
            endcase
        end
    end

    assign bus.control_word = cw;
    assign bus.step         = step_r;
    assign bus.halt         = (mode == HALTED);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed and random instructions against
// a table-driven microprogram model.
module tb_control_unit;

    localparam int MS = 5;
    localparam logic [15:0] OE_MASK = 16'h1294;

    logic clk = 1'b0;
    logic reset = 1'b1;

    control_unit_if bus ();

    control_unit #(.MAX_STEPS(MS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [15:0] prog [16][8];
    int          len  [16];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] expect_cw(input int op, input int k, input logic fc, input logic fz);
        logic [15:0] w;
        if (k == 0)      w = 16'h000C;
        else if (k == 1) w = 16'h0051;
        else             w = prog[op][k];
        if (k == 2 && op == 7 && !fc) w = 16'h0000;
        if (k == 2 && op == 8 && !fz) w = 16'h0000;
        return w;
    endfunction

    function automatic int instr_len(input int op);
`ifdef SHORT_CYCLE_EN
        return len[op];
`else
        return MS;
`endif
    endfunction

    // Runs one instruction from T0; optionally forces an async reset during step abort_at.
    task automatic run_instr(input int op, input int abort_at);
        int n;
        logic [15:0] w;
        n = instr_len(op);
        bus.opcode  = 4'(op);
        bus.operand = 4'($urandom_range(0, 15));
        for (int k = 0; k < n; k++) begin
            bus.flag_carry = 1'($urandom_range(0, 1));
            bus.flag_zero  = 1'($urandom_range(0, 1));
            #1;
            w = expect_cw(op, k, bus.flag_carry, bus.flag_zero);
            check($sformatf("op%0h_T%0d_step", op, k), {13'd0, bus.step}, 16'(k));
            check($sformatf("op%0h_T%0d_cw", op, k), bus.control_word, w);
            check($sformatf("op%0h_T%0d_halt", op, k), {15'd0, bus.halt}, 16'd0);
            check($sformatf("op%0h_T%0d_oe", op, k),
                  16'($countones(bus.control_word & OE_MASK) <= 1), 16'd1);
            if (k == abort_at) begin
                #1 reset = 1'b1;
                #1;
                check("abort_cw", bus.control_word, 16'h0000);
                check("abort_step", {13'd0, bus.step}, 16'd0);
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            len[i] = 3;
            for (int j = 0; j < 8; j++) prog[i][j] = 16'h0000;
        end
        prog[1][2]  = 16'h0088; prog[1][3] = 16'h0110;                        len[1] = 4;
        prog[2][2]  = 16'h0088; prog[2][3] = 16'h0410; prog[2][4] = 16'h3100; len[2] = 5;
        prog[3][2]  = 16'h0088; prog[3][3] = 16'h0410; prog[3][4] = 16'h3900; len[3] = 5;
        prog[4][2]  = 16'h0088; prog[4][3] = 16'h0220;                        len[4] = 4;
        prog[5][2]  = 16'h0180;
        prog[6][2]  = 16'h0082;
        prog[7][2]  = 16'h0082;
        prog[8][2]  = 16'h0082;
        prog[14][2] = 16'h4200;
        prog[15][2] = 16'h8000;

        bus.opcode = 4'h0; bus.operand = 4'h0;
        bus.flag_carry = 1'b0; bus.flag_zero = 1'b0;

        // Reset held for three cycles.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_cw", bus.control_word, 16'h0000);
            check("rst_step", {13'd0, bus.step}, 16'd0);
            check("rst_halt", {15'd0, bus.halt}, 16'd0);
        end
        reset = 1'b0;

        // Directed: NOP, LDA, SUB, ADD, jumps, then return to T0 after each.
        run_instr(0, -1);
        run_instr(1, -1);
        run_instr(3, -1);
        run_instr(2, -1);
        for (int r = 0; r < 4; r++) begin
            run_instr(7, -1);
            run_instr(8, -1);
        end
        run_instr(4, -1);

        // Async reset mid-T3 of ADD, then a clean fetch.
        run_instr(2, 3);
        run_instr(1, -1);

        // Random instruction stream, HLT excluded.
        for (int r = 0; r < 40; r++) run_instr($urandom_range(0, 14), -1);

        // HLT: freeze for 20 cycles with only the halt bit set.
        run_instr(15, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.opcode = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hlt_T%0d_cw", k), bus.control_word, expect_cw(15, k, 1'b0, 1'b0));
            check($sformatf("hlt_T%0d_halt", k), {15'd0, bus.halt}, 16'd0);
            @(posedge clk);
            @(negedge clk);
        end
        for (int c = 0; c < 20; c++) begin
            bus.opcode = 4'($urandom_range(0, 15));
            #1;
            check("halted_halt", {15'd0, bus.halt}, 16'd1);
            check("halted_cw", bus.control_word, 16'h8000);
            check("halted_step", {13'd0, bus.step}, 16'd2);
            @(negedge clk);
        end
        #1 reset = 1'b1;
        #1;
        check("unhalt_halt", {15'd0, bus.halt}, 16'd0);
        check("unhalt_step", {13'd0, bus.step}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        run_instr(5, -1);
        run_instr(6, -1);
        run_instr(14, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
